// File: rtl/access_sequencer.sv
// access_sequencer: two-factor door access FSM. A camera face match followed by
// a correct touchscreen PIN opens the lock motor. Timeouts, wrong PINs and face
// rejects count as failures, and enough consecutive failures cause a lockout.
// Optional macro ACCESS_LOG_EN: when defined, unlock_count counts successful
// unlocks and saturates at 255. When undefined, unlock_count is tied to 0.
// Ports:
//   CLOCK_50, reset (async, active-high)
//   cam_done / unlock          : camera result. Only the rising edge of cam_done is used.
//   pin_valid / pin_ok         : PIN entry strobe and its result
//   exit_req                   : GUI exit request (level)
//   motor_open, gui_select,
//   lockout                    : decoded from the registered state
//   fail_count, state_o,
//   status_vec, unlock_count   : status back to the display and touchscreen
module access_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_500_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int          CNT_W          = 31
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cam_done,
  input  logic       unlock,
  input  logic       pin_valid,
  input  logic       pin_ok,
  input  logic       exit_req,
  output logic       motor_open,
  output logic       gui_select,
  output logic       lockout,
  output logic [2:0] fail_count,
  output logic [2:0] state_o,
  output logic [2:0] status_vec,
  output logic [7:0] unlock_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PIN_WAIT = 3'd1,
    UNLOCKED = 3'd2,
    LOCKOUT  = 3'd3,
    FAIL     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_UNLOCK  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_LOCKOUT = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]       MAX_F      = 3'(MAX_FAILS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_dec;
  logic             cam_done_q;
  logic             cam_rise;
  logic             face_ok;
  logic             cam_seen;
  logic [2:0]       fail_inc;
  logic             cnt_zero;
  logic             enter_unlock;

  assign cam_rise     = cam_done & ~cam_done_q;
  assign cnt_zero     = (cnt == '0);
  assign cnt_dec      = cnt_zero ? cnt : cnt - 1'b1;
  // The fail counter saturates at 7, so MAX_FAILS=7 still reaches lockout.
  assign fail_inc     = (fail_count == 3'd7) ? 3'd7 : fail_count + 3'd1;
  assign enter_unlock = (state == PIN_WAIT) && pin_valid && pin_ok;

  // State register. The shared down-counter is registered here as well.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and counter update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (cam_rise) begin
          if (unlock) begin
            state_nxt = PIN_WAIT;
            cnt_nxt   = LD_TIMEOUT;
          end else begin
            state_nxt = FAIL;
          end
        end
      end
      PIN_WAIT: begin
        cnt_nxt = cnt_dec;
        // A PIN strobe wins over a timeout on the same cycle. A timeout wins over exit.
        if (pin_valid) begin
          if (pin_ok) begin
            state_nxt = UNLOCKED;
            cnt_nxt   = LD_UNLOCK;
          end else begin
            state_nxt = FAIL;
          end
        end else if (cnt_zero) begin
          state_nxt = FAIL;
        end else if (exit_req) begin
          state_nxt = IDLE;
        end
      end
      FAIL: begin
        if (fail_inc >= MAX_F) begin
          state_nxt = LOCKOUT;
          cnt_nxt   = LD_LOCKOUT;
        end else begin
          state_nxt = IDLE;
        end
      end
      UNLOCKED, LOCKOUT: begin
        cnt_nxt = cnt_dec;
        if (cnt_zero) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode. This logic depends only on the registered state, so these
  // outputs follow an input by exactly one clock. They also clear together with the async reset.
  always_comb begin
    motor_open = 1'b0;
    gui_select = 1'b0;
    lockout    = 1'b0;
    case (state)
      PIN_WAIT: gui_select = 1'b1;
      UNLOCKED: motor_open = 1'b1;
      LOCKOUT:  lockout    = 1'b1;
      default:  ;
    endcase
  end

  assign state_o    = state;
  assign status_vec = {cam_seen, face_ok, gui_select};

  // Edge detector, failure count and status flags.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cam_done_q <= 1'b0;
      fail_count <= 3'd0;
      face_ok    <= 1'b0;
      cam_seen   <= 1'b0;
    end else begin
      cam_done_q <= cam_done;

      if (state == FAIL)
        fail_count <= fail_inc;
      else if (enter_unlock || (state == LOCKOUT && cnt_zero))
        fail_count <= 3'd0;

      if (state == IDLE && cam_rise && unlock)
        face_ok <= 1'b1;
      else if (state == FAIL)
        face_ok <= 1'b0;

      // A cam rise outside IDLE is discarded, so it does not set the flag.
      if (state != IDLE && state_nxt == IDLE)
        cam_seen <= 1'b0;
      else if (state == IDLE && cam_rise)
        cam_seen <= 1'b1;
    end
  end

`ifdef ACCESS_LOG_EN
  logic [7:0] unlock_cnt_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      unlock_cnt_q <= 8'd0;
    else if (enter_unlock && unlock_cnt_q != 8'hFF)
      unlock_cnt_q <= unlock_cnt_q + 8'd1;
  end

  assign unlock_count = unlock_cnt_q;
`else
  assign unlock_count = 8'd0;
`endif

endmodule

// File: tb/tb_access_sequencer.sv
// Directed bench for access_sequencer. The bench uses short cycle counts
// (timeout 20, unlock 10, lockout 30, max fails 3).
module tb_access_sequencer;

`ifdef ACCESS_LOG_EN
  localparam int LOG = 1;
`else
  localparam int LOG = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cam_done, unlock, pin_valid, pin_ok, exit_req;
  logic       motor_open, gui_select, lockout;
  logic [2:0] fail_count, state_o, status_vec;
  logic [7:0] unlock_count;
  logic [7:0] exp_uc;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  access_sequencer #(
    .TIMEOUT_CYCLES(20),
    .UNLOCK_CYCLES (10),
    .LOCKOUT_CYCLES(30),
    .MAX_FAILS     (3),
    .CNT_W         (31)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .cam_done    (cam_done),
    .unlock      (unlock),
    .pin_valid   (pin_valid),
    .pin_ok      (pin_ok),
    .exit_req    (exit_req),
    .motor_open  (motor_open),
    .gui_select  (gui_select),
    .lockout     (lockout),
    .fail_count  (fail_count),
    .state_o     (state_o),
    .status_vec  (status_vec),
    .unlock_count(unlock_count)
  );

  // Advance one clock. Sampling and driving happen 1 time unit after the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cam_done = 0; unlock = 0; pin_valid = 0; pin_ok = 0; exit_req = 0;
    step(2);
    if ({motor_open, gui_select, lockout} !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got %b exp 000", {motor_open, gui_select, lockout}); end n_checks++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_o); end n_checks++;
    if (fail_count !== 3'd0) begin n_fail++; $display("FAIL reset_fails: got %0d exp 0", fail_count); end n_checks++;
    if (status_vec !== 3'd0) begin n_fail++; $display("FAIL reset_status: got %b exp 000", status_vec); end n_checks++;
    if (unlock_count !== 8'd0) begin n_fail++; $display("FAIL reset_ucount: got %0d exp 0", unlock_count); end n_checks++;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_happy_path;
    cam_done = 1; unlock = 1;
    step(1);
    if (gui_select !== 1'b1) begin n_fail++; $display("FAIL happy_gui: got %b exp 1", gui_select); end n_checks++;
    if (state_o !== 3'd1) begin n_fail++; $display("FAIL happy_pinwait: got %0d exp 1", state_o); end n_checks++;
    if (status_vec !== 3'b111) begin n_fail++; $display("FAIL happy_status: got %b exp 111", status_vec); end n_checks++;
    unlock = 0;
    step(1);
    cam_done = 0;
    step(3);
    pin_valid = 1; pin_ok = 1;
    step(1);
    pin_valid = 0; pin_ok = 0;
    if (motor_open !== 1'b1 || gui_select !== 1'b0) begin n_fail++; $display("FAIL happy_open: got motor=%b gui=%b exp 1/0", motor_open, gui_select); end n_checks++;
    // A cam rise during UNLOCKED must be ignored. cam_done is held high through the return to IDLE.
    cam_done = 1; unlock = 1;
    for (int i = 1; i < 10; i++) begin
      step(1);
      if (motor_open !== 1'b1 || state_o !== 3'd2) begin n_fail++; $display("FAIL happy_hold%0d: got motor=%b state=%0d exp 1/2", i, motor_open, state_o); end n_checks++;
    end
    step(1);
    if (motor_open !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL happy_close: got motor=%b state=%0d exp 0/0", motor_open, state_o); end n_checks++;
    if (fail_count !== 3'd0) begin n_fail++; $display("FAIL happy_fails: got %0d exp 0", fail_count); end n_checks++;
    exp_uc = 8'(LOG);
    if (unlock_count !== exp_uc) begin n_fail++; $display("FAIL happy_ucount: got %0d exp %0d", unlock_count, exp_uc); end n_checks++;
    step(3);
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL held_cam_retrigger: got %0d exp 0", state_o); end n_checks++;
    cam_done = 0; unlock = 0;
    step(1);
  endtask

  task automatic test_simultaneous;
    cam_done = 1; unlock = 1;
    step(1);
    cam_done = 0; unlock = 0;
    pin_valid = 1; pin_ok = 1; exit_req = 1;
    step(1);
    pin_valid = 0; pin_ok = 0; exit_req = 0;
    if (state_o !== 3'd2 || motor_open !== 1'b1) begin n_fail++; $display("FAIL simul_unlock: got state=%0d motor=%b exp 2/1", state_o, motor_open); end n_checks++;
    step(10);
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL simul_idle: got %0d exp 0", state_o); end n_checks++;
    exp_uc = 8'(2 * LOG);
    if (unlock_count !== exp_uc) begin n_fail++; $display("FAIL simul_ucount: got %0d exp %0d", unlock_count, exp_uc); end n_checks++;
  endtask

  task automatic test_timeout;
    cam_done = 1; unlock = 1;
    step(1);
    cam_done = 0; unlock = 0;
    for (int i = 1; i < 20; i++) begin
      step(1);
      if (state_o !== 3'd1) begin n_fail++; $display("FAIL timeout_wait%0d: got %0d exp 1", i, state_o); end n_checks++;
    end
    step(1);
    if (state_o !== 3'd4 || gui_select !== 1'b0) begin n_fail++; $display("FAIL timeout_fail: got state=%0d gui=%b exp 4/0", state_o, gui_select); end n_checks++;
    step(1);
    if (state_o !== 3'd0 || fail_count !== 3'd1) begin n_fail++; $display("FAIL timeout_count: got state=%0d fails=%0d exp 0/1", state_o, fail_count); end n_checks++;
  endtask

  task automatic test_exit;
    cam_done = 1; unlock = 1;
    step(1);
    cam_done = 0; unlock = 0;
    step(2);
    exit_req = 1;
    step(1);
    exit_req = 0;
    if (state_o !== 3'd0 || fail_count !== 3'd1) begin n_fail++; $display("FAIL exit_idle: got state=%0d fails=%0d exp 0/1", state_o, fail_count); end n_checks++;
    if (status_vec[2] !== 1'b0 || gui_select !== 1'b0) begin n_fail++; $display("FAIL exit_status: got seen=%b gui=%b exp 0/0", status_vec[2], gui_select); end n_checks++;
  endtask

  task automatic test_face_reject;
    cam_done = 1; unlock = 0;
    step(1);
    cam_done = 0;
    if (state_o !== 3'd4) begin n_fail++; $display("FAIL reject_fail: got %0d exp 4", state_o); end n_checks++;
    step(1);
    if (state_o !== 3'd0 || fail_count !== 3'd2) begin n_fail++; $display("FAIL reject_count: got state=%0d fails=%0d exp 0/2", state_o, fail_count); end n_checks++;
  endtask

  task automatic test_lockout;
    reset = 1; step(1); reset = 0; step(1);
    for (int n = 1; n <= 3; n++) begin
      cam_done = 1; unlock = 1;
      step(1);
      cam_done = 0; unlock = 0;
      step(1);
      pin_valid = 1; pin_ok = 0;
      step(1);
      pin_valid = 0;
      if (state_o !== 3'd4) begin n_fail++; $display("FAIL wrongpin%0d_fail: got %0d exp 4", n, state_o); end n_checks++;
      step(1);
      if (fail_count !== 3'(n)) begin n_fail++; $display("FAIL wrongpin%0d_count: got %0d exp %0d", n, fail_count, n); end n_checks++;
    end
    if (lockout !== 1'b1 || state_o !== 3'd3) begin n_fail++; $display("FAIL lockout_enter: got lockout=%b state=%0d exp 1/3", lockout, state_o); end n_checks++;
    // A cam rise and a PIN strobe during LOCKOUT are both discarded.
    cam_done = 1; unlock = 1; pin_valid = 1; pin_ok = 1;
    step(1);
    pin_valid = 0; pin_ok = 0;
    for (int i = 2; i < 30; i++) begin
      step(1);
      if (lockout !== 1'b1) begin n_fail++; $display("FAIL lockout_hold%0d: got %b exp 1", i, lockout); end n_checks++;
    end
    step(1);
    if (lockout !== 1'b0 || state_o !== 3'd0 || fail_count !== 3'd0) begin n_fail++; $display("FAIL lockout_exit: got lockout=%b state=%0d fails=%0d exp 0/0/0", lockout, state_o, fail_count); end n_checks++;
    step(2);
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL lockout_no_retrigger: got %0d exp 0", state_o); end n_checks++;
    cam_done = 0; unlock = 0;
    step(1);
  endtask

  task automatic test_reset_mid_unlock;
    cam_done = 1; unlock = 1;
    step(1);
    cam_done = 0; unlock = 0;
    pin_valid = 1; pin_ok = 1;
    step(1);
    pin_valid = 0; pin_ok = 0;
    step(3);
    if (motor_open !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got %b exp 1", motor_open); end n_checks++;
    reset = 1;
    #1;
    if (motor_open !== 1'b0) begin n_fail++; $display("FAIL midreset_motor: got %b exp 0", motor_open); end n_checks++;
    if ({gui_select, lockout, fail_count, state_o, status_vec} !== 11'd0) begin n_fail++; $display("FAIL midreset_outs: got %b exp 0", {gui_select, lockout, fail_count, state_o, status_vec}); end n_checks++;
    if (unlock_count !== 8'd0) begin n_fail++; $display("FAIL midreset_ucount: got %0d exp 0", unlock_count); end n_checks++;
    step(1);
    reset = 0;
    step(1);
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL midreset_idle: got %0d exp 0", state_o); end n_checks++;
  endtask

  initial begin
    test_reset;
    test_happy_path;
    test_simultaneous;
    test_timeout;
    test_exit;
    test_face_reject;
    test_lockout;
    test_reset_mid_unlock;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/access_sequencer.md
Name: access_sequencer

Overview:
- Two-factor access controller between the camera (face-match result), the touchscreen (PIN result word) and the lock motor / VGA source select.
- Consumes the camera unlock/cam_done pair and decoded touchscreen PIN events.
- Produces the motor open command, the GUI/D8M display select, fail/lockout status, and the 3-bit status vector returned to the touchscreen.

Parameters:
- TIMEOUT_CYCLES, 500_000_000: max cycles in PIN_WAIT before aborting (10 s at 50 MHz).
- UNLOCK_CYCLES, 250_000_000: cycles motor_open stays high (5 s).
- LOCKOUT_CYCLES, 1_500_000_000: lockout duration (30 s).
- MAX_FAILS, 3: consecutive failures that trigger lockout, legal range 1..7.
- CNT_W, 31: width of the shared down-counter; must hold the largest *_CYCLES value.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cam_done  in  1  camera analysis complete (level); only its rising edge is used.
- unlock  in  1  camera face-match result; sampled on the cycle cam_done rises.
- pin_valid  in  1  one-cycle strobe from touchscreen: PIN entry finished.
- pin_ok  in  1  PIN correct; qualified by pin_valid.
- exit_req  in  1  GUI exit request (touchscreen word bit 4); level.
- motor_open  out  1  drive lock motor to open position.
- gui_select  out  1  1 = GUI VGA source, 0 = D8M camera source.
- lockout  out  1  high while in LOCKOUT.
- fail_count  out  3  current consecutive failure count.
- state_o  out  3  encoded FSM state for hex/LED display.
- status_vec  out  3  {cam_done_seen, face_ok, gui_select} returned to the touchscreen.
- unlock_count  out  8  successful unlocks; see Optional Feature.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; all outputs 0.
  - Counter 0; cam_done edge register 0.
- cam_rise = cam_done & ~cam_done_q, with cam_done_q registered every cycle.
- State encoding on state_o: IDLE=0, PIN_WAIT=1, UNLOCKED=2, LOCKOUT=3, FAIL=4.
- IDLE:
  - gui_select=0.
  - On cam_rise with unlock=1 → PIN_WAIT: counter loads TIMEOUT_CYCLES-1, face_ok=1, gui_select=1 on the next cycle.
  - On cam_rise with unlock=0 → FAIL.
  - Otherwise stay in IDLE.
- PIN_WAIT:
  - gui_select=1; counter decrements each cycle.
  - pin_valid & pin_ok → UNLOCKED: counter loads UNLOCK_CYCLES-1, fail_count clears to 0.
  - pin_valid & ~pin_ok → FAIL.
  - Counter==0 with no pin_valid → FAIL (timeout).
  - exit_req=1 with no pin_valid → IDLE, counting as neither success nor failure.
  - Priority: pin_valid > timeout > exit_req.
- FAIL (one cycle):
  - fail_count increments, saturating at 7.
  - If the new fail_count ≥ MAX_FAILS → LOCKOUT, counter loads LOCKOUT_CYCLES-1; otherwise → IDLE.
  - face_ok clears.
- UNLOCKED:
  - motor_open=1, gui_select=0; counter decrements.
  - Counter==0 → IDLE, with motor_open falling on that transition.
  - Camera and PIN inputs are ignored.
- LOCKOUT:
  - lockout=1, gui_select=0; all inputs ignored.
  - Counter==0 → IDLE with fail_count cleared.
- Outputs are registered; motor_open and gui_select change exactly one cycle after the triggering input edge/strobe.
- cam_done_seen in status_vec = sticky flag, set on cam_rise, cleared on entry to IDLE from any state other than IDLE.
- A cam_rise in any state other than IDLE is discarded. It is not queued.
- reset asserted mid-UNLOCKED drops motor_open asynchronously, the same cycle.

Optional Feature:
- Macro ACCESS_LOG_EN.
- Defined: unlock_count increments by 1 on each PIN_WAIT→UNLOCKED transition, saturating at 255. It is reset to 0 only by reset; LOCKOUT does not clear it.
- Undefined: unlock_count is tied to 8'd0 and no counter register is synthesized.

Test Plan (TIMEOUT_CYCLES=20, UNLOCK_CYCLES=10, LOCKOUT_CYCLES=30, MAX_FAILS=3):
- Happy path: cam_done rise with unlock=1, then pin_valid/pin_ok pulse 5 cycles later.
  - Response: gui_select=1 one cycle after the cam rise.
  - Response: motor_open=1 one cycle after pin_valid and high for exactly 10 cycles.
  - Response: return to IDLE; fail_count=0; unlock_count=1 (macro on).
- Three wrong PINs, each preceded by a face match → fail_count 1, 2, 3; lockout=1 for 30 cycles, then state_o=0 and fail_count=0.
- Timeout: face match, no pin_valid → FAIL after 20 cycles in PIN_WAIT; fail_count=1; gui_select returns to 0.
- Simultaneous events: pin_valid=1, pin_ok=1 and exit_req=1 on the same cycle → UNLOCKED, not IDLE.
- Discarded input: cam_done rises during UNLOCKED or LOCKOUT → no state change; cam_done held high across IDLE re-entry → no new trigger without a fresh rise.
- Reset mid-operation: assert reset for 1 cycle mid-UNLOCKED → motor_open drops immediately, all outputs 0, unlock_count=0.
